// File: rtl/midi_pkg.sv
// Shared constants, receiver state type and message-length helper for the MIDI receiver.
package midi_pkg;

  localparam logic [3:0] NibProgram   = 4'hC;
  localparam logic [3:0] NibChanPress = 4'hD;
  localparam logic [7:0] SysCommonMin = 8'hF0;
  localparam logic [7:0] RealTimeMin  = 8'hF8;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  function automatic logic [1:0] data_bytes(input logic [7:0] status);
    return (status[7:4] == NibProgram || status[7:4] == NibChanPress) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// Serial-line synchroniser and 8N1 byte receiver producing single-cycle byte/frame-error strobes.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1600,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HalfBit = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [CntW-1:0] CntOne  = 1;
  localparam logic [CntW-1:0] HalfEnd = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] FullEnd = CntW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line;
  rx_state_e              state_q;
  logic [CntW-1:0]        cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;

  assign line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      prev_q     <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], serial};
      prev_q     <= line;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (prev_q && !line) state_q <= StStart;
        end
        StStart: begin
          // Mid-start-bit recheck rejects short glitches.
          if (cnt_q == HalfEnd) begin
            cnt_q   <= '0;
            state_q <= line ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StData: begin
          if (cnt_q == FullEnd) begin
            cnt_q     <= '0;
            shift_q   <= {line, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StStop: begin
          if (cnt_q == FullEnd) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (line) begin
              rx_byte    <= shift_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_rx.sv
// MIDI message receiver: byte receiver, channel/real-time message parser and held output register.
// Define MIDI_RX_RUNNING_STATUS_EN to keep running status across emitted channel messages.
module midi_msg_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1600,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic [23:0] msg_data,
  output logic [1:0]  msg_len,
  output logic        frame_err,
  output logic        overrun
);

`ifdef MIDI_RX_RUNNING_STATUS_EN
  localparam bit KeepRunning = 1'b1;
`else
  localparam bit KeepRunning = 1'b0;
`endif

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic [7:0]  rs_q, rs_d;
  logic        cnt_q, cnt_d;
  logic [7:0]  d1_q, d1_d;
  logic        emit;
  logic [23:0] emit_data;
  logic [1:0]  emit_len;

  midi_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .serial    (serial),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // rs_q[7] == 0 means no running status is held.
  always_comb begin
    rs_d      = rs_q;
    cnt_d     = cnt_q;
    d1_d      = d1_q;
    emit      = 1'b0;
    emit_data = '0;
    emit_len  = '0;
    if (frame_err) begin
      cnt_d = 1'b0;
    end else if (byte_valid) begin
      if (rx_byte >= RealTimeMin) begin
        emit      = 1'b1;
        emit_data = {rx_byte, 16'h0000};
        emit_len  = 2'd1;
      end else if (rx_byte >= SysCommonMin) begin
        rs_d  = '0;
        cnt_d = 1'b0;
      end else if (rx_byte[7]) begin
        rs_d  = rx_byte;
        cnt_d = 1'b0;
      end else if (rs_q[7]) begin
        if (data_bytes(rs_q) == 2'd1) begin
          emit      = 1'b1;
          emit_data = {rs_q, rx_byte, 8'h00};
          emit_len  = 2'd2;
          cnt_d     = 1'b0;
          if (!KeepRunning) rs_d = '0;
        end else if (!cnt_q) begin
          d1_d  = rx_byte;
          cnt_d = 1'b1;
        end else begin
          emit      = 1'b1;
          emit_data = {rs_q, d1_q, rx_byte};
          emit_len  = 2'd3;
          cnt_d     = 1'b0;
          if (!KeepRunning) rs_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q      <= '0;
      cnt_q     <= 1'b0;
      d1_q      <= '0;
      msg_valid <= 1'b0;
      msg_data  <= '0;
      msg_len   <= '0;
      overrun   <= 1'b0;
    end else begin
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      d1_q    <= d1_d;
      overrun <= 1'b0;
      if (emit) begin
        if (!msg_valid || msg_ready) begin
          msg_valid <= 1'b1;
          msg_data  <= emit_data;
          msg_len   <= emit_len;
        end else begin
          overrun <= 1'b1;
        end
      end else if (msg_valid && msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/midi_msg_rx.md
MIDI_MSG_RX -- requirements
Module: midi_msg_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1600, clk cycles per MIDI bit (50 MHz / 31250 baud).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, serial input synchroniser depth (range 2-4).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port serial, input, 1, asynchronous MIDI line; idles high.
REQ-006 SHALL have port msg_valid, output, 1, held message available.
REQ-007 SHALL have port msg_ready, input, 1, consumer accepts the held message.
REQ-008 SHALL have port msg_data, output, 24, message bytes: status [23:16], data1 [15:8], data2 [7:0]; unused bytes are zero.
REQ-009 SHALL have port msg_len, output, 2, byte count of the held message (1-3).
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a complete message is dropped.

Function
REQ-012 SHALL pass serial through SYNC_STAGES flops before any use.
REQ-013 SHALL run the byte receiver through states IDLE, START, DATA and STOP.
- IDLE->START on a synced high-to-low transition.
- START: after CLKS_PER_BIT/2 cycles, resample the line; if high, return to IDLE with no output (glitch rejection); if low, go to DATA.
REQ-014 In DATA, the receiver SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample, then go to STOP.
REQ-015 In STOP, the receiver SHALL sample one bit after CLKS_PER_BIT cycles.
- Sampled 1: deliver the byte to the parser.
- Sampled 0: pulse frame_err, discard the byte, clear the parser's partial message.
- Either way, return to IDLE.
REQ-016 A channel status byte (0x80-0xEF) SHALL load running status and clear the collected data count.
- Required data bytes: 1 for status nibble 0xC or 0xD; 2 for all others.
REQ-017 A data byte (bit7=0) SHALL be discarded when no running status is held; otherwise it SHALL be stored.
- When the required count is reached, the message is emitted and the data count is cleared; running status is kept.
REQ-018 Messages SHALL be emitted with these lengths:
- 1 data byte: msg_len=2, data2=0.
- 2 data bytes: msg_len=3.
REQ-019 Bytes 0xF0-0xF7 SHALL clear running status and be dropped; SysEx payload is discarded until the next status byte.
REQ-020 Bytes 0xF8-0xFF (real-time) SHALL emit immediately with msg_data={byte,16'h0} and msg_len=1, leaving running status and partial data untouched.
REQ-021 msg_valid SHALL rise on the cycle after the stop-bit sample that completes a message.
- msg_data and msg_len hold stable while msg_valid=1 and msg_ready=0.
REQ-022 The handshake completes on a cycle with msg_valid=1 and msg_ready=1; msg_valid drops on the next cycle unless a new message loads on that same cycle.
REQ-023 When a completed message arrives while msg_valid=1 and msg_ready=0:
- The new message is dropped and overrun pulses.
- The held message is unchanged.
- On the same cycle as an accepting handshake, the new message loads and overrun does not pulse.
REQ-024 Bit counters SHALL be wide enough for CLKS_PER_BIT with no wrap-around before terminal count.

Reset
REQ-025 While rst=1, the block SHALL hold the following on the next clk edge:
- receiver in IDLE, counters 0;
- running status and partial data cleared;
- synchroniser flops at 1;
- msg_valid=0, msg_data=0, msg_len=0, frame_err=0, overrun=0.
REQ-026 Reset asserted mid-byte SHALL abandon that byte; after deassertion, the receiver waits for a fresh falling edge.

Configuration
REQ-027 With MIDI_RX_RUNNING_STATUS_EN defined, running status SHALL behave per REQ-016 to REQ-017.
REQ-028 Without MIDI_RX_RUNNING_STATUS_EN, running status SHALL be cleared after every emitted channel message, so data bytes without a new status byte are discarded.

Structure
REQ-029 Package midi_pkg SHALL hold:
- status-nibble constants;
- the real-time threshold 8'hF8;
- the receiver state enum;
- a function returning the required data-byte count for a status byte.
REQ-030 Sub-module midi_uart_rx SHALL contain the synchroniser and the byte receiver (REQ-012 to REQ-015).
- It outputs byte, byte_valid and frame_err.
- midi_msg_rx instantiates it and holds the parser and output register.

Verification (CLKS_PER_BIT=16)
REQ-031 Bytes 0x90,0x3C,0x64 sent, msg_ready=1 -> one message: msg_data=0x903C64, msg_len=3.
REQ-032 Bytes 0x90,0x3C,0x64,0x3C,0x00 sent -> 0x903C64 then 0x903C00 (running status); with the macro undefined -> only 0x903C64.
REQ-033 Bytes 0xC0,0x05 sent -> msg_data=0xC00500, msg_len=2.
REQ-034 Bytes 0x90,0xF8,0x3C,0x64 sent -> 0xF80000 (msg_len=1), then 0x903C64.
REQ-035 Abnormal serial input:
- 4-cycle low glitch -> no output, no frame_err.
- Byte with stop bit 0 -> frame_err pulse, no msg_valid.
REQ-036 msg_ready=0, two full 0x80 0x40 0x00 messages sent -> first held, overrun pulses once, msg_data=0x804000.
- Reset mid-byte, then a clean 0xFE -> 0xFE0000 only.
